// File: rtl/scalar_operand_sequencer.sv
// Buffers vector-scalar operations and, for the head operation, issues one beat
// per group of LANES elements with lane-valid mask and last flag for the replicator.
module scalar_operand_sequencer #(
  parameter int DEPTH    = 2,
  parameter int VL_WIDTH = 8,
  parameter int LANES    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_scalar,
  input  logic [1:0]          in_vsew,
  input  logic [VL_WIDTH-1:0] in_vl,
  output logic                beat_valid,
  input  logic                beat_ready,
  output logic [31:0]         scalar_out,
  output logic [1:0]          vsew_out,
  output logic [LANES-1:0]    lane_mask,
  output logic                beat_last,
  output logic                busy
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int LANE_SH = $clog2(LANES);
  localparam int EXT_W   = VL_WIDTH + 1;
  localparam int BIDX_W  = EXT_W - LANE_SH;

  logic [31:0]         scalar_mem [DEPTH];
  logic [1:0]          vsew_mem   [DEPTH];
  logic [VL_WIDTH-1:0] vl_mem     [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [BIDX_W-1:0] b_reg;

  logic                head_valid;
  logic [31:0]         head_scalar;
  logic [1:0]          head_vsew;
  logic [VL_WIDTH-1:0] head_vl;
  logic [EXT_W-1:0]    n_beats;
  logic [EXT_W-1:0]    remaining;
  logic [LANES-1:0]    lane_live;
  logic                head_last;
  logic                accept;
  logic                push;
  logic                xfer;
  logic                pop;

  assign head_valid  = (count_reg != '0);
  assign in_ready    = (count_reg != CNT_W'(DEPTH));
  assign head_scalar = scalar_mem[rd_ptr_reg];
  assign head_vsew   = vsew_mem[rd_ptr_reg];
  assign head_vl     = vl_mem[rd_ptr_reg];

  // One extra bit keeps ceil(vl/LANES) exact at the maximum vl.
  assign n_beats   = ({1'b0, head_vl} + EXT_W'(LANES - 1)) >> LANE_SH;
  assign remaining = {1'b0, head_vl} - {b_reg, {LANE_SH{1'b0}}};
  assign head_last = ({{LANE_SH{1'b0}}, b_reg} == (n_beats - EXT_W'(1)));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_live[gi] = (remaining > EXT_W'(gi));
    end
  endgenerate

  // Zero-length operations are acknowledged but never stored.
  assign accept = in_valid & in_ready;
  assign push   = accept & (in_vl != '0);
  assign xfer   = head_valid & beat_ready;
  assign pop    = xfer & head_last;

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      b_reg      <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      if (xfer) begin
        b_reg <= head_last ? '0 : b_reg + BIDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      scalar_mem[wr_ptr_reg] <= in_scalar;
      vsew_mem[wr_ptr_reg]   <= in_vsew;
      vl_mem[wr_ptr_reg]     <= in_vl;
    end
  end

  // Data outputs are forced to zero whenever no beat is presented.
  always_comb begin
    beat_valid = head_valid;
    busy       = head_valid;
    scalar_out = '0;
    vsew_out   = '0;
    lane_mask  = '0;
    beat_last  = 1'b0;
    if (head_valid) begin
      scalar_out = head_scalar;
      vsew_out   = head_vsew;
      lane_mask  = lane_live;
      beat_last  = head_last;
    end
  end

endmodule
